// File: rtl/lz77_decoder_if.sv
// Handshake and data bundle between an LZ77 triple source and the decoder.
// err exists only when LZ77_DEC_ERR_EN is defined.
interface lz77_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;
  logic       out_valid;
  logic [7:0] out_char;
  logic       finish;
`ifdef LZ77_DEC_ERR_EN
  logic       err;

  modport master (
    output in_valid, offset, match_len, char_nxt,
    input  in_ready, out_valid, out_char, finish, err
  );
  modport slave (
    input  in_valid, offset, match_len, char_nxt,
    output in_ready, out_valid, out_char, finish, err
  );
`else
  modport master (
    output in_valid, offset, match_len, char_nxt,
    input  in_ready, out_valid, out_char, finish
  );
  modport slave (
    input  in_valid, offset, match_len, char_nxt,
    output in_ready, out_valid, out_char, finish
  );
`endif
endinterface

// File: rtl/lz77_decoder.sv
// LZ77 decoder: (offset, match_len, char_nxt) triples -> one char per cycle, 9-char history.
// Optional macro LZ77_DEC_ERR_EN adds a sticky err flag for references outside valid history.
module lz77_decoder (
  input  logic          clk,
  input  logic          reset,
  lz77_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;

  state_t     state;
  logic [2:0] rem;
  logic [3:0] off_q;
  logic [7:0] char_q;
  logic [7:0] hist [0:8];
  logic [3:0] rd_idx;
  logic       emit;
  logic       accept;
  logic [7:0] emit_char;

  assign bus.in_ready = (state == IDLE) || (state == LIT);
  assign rd_idx       = (off_q > 4'd8) ? 4'd8 : off_q;
  assign emit         = (state == COPY) || (state == LIT);
  assign emit_char    = (state == COPY) ? hist[rd_idx] : char_q;
  // A terminator literal wins over any triple offered at the same edge.
  assign accept       = bus.in_valid && bus.in_ready && !(state == LIT && char_q == 8'h24);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rem           <= 3'd0;
      off_q         <= 4'd0;
      char_q        <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.out_char  <= 8'h00;
      bus.finish    <= 1'b0;
      for (int i = 0; i < 9; i++) hist[i] <= 8'h00;
    end else begin
      bus.out_valid <= 1'b0;
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_char  <= emit_char;
        hist[0]       <= emit_char;
        for (int i = 1; i < 9; i++) hist[i] <= hist[i-1];
      end
      case (state)
        COPY: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) state <= LIT;
        end
        LIT: begin
          if (char_q == 8'h24) begin
            bus.finish <= 1'b1;
            state      <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
      // Later assignment overrides the LIT->IDLE default when a new triple streams in.
      if (accept) begin
        off_q  <= bus.offset;
        char_q <= bus.char_nxt;
        rem    <= bus.match_len;
        state  <= (bus.match_len != 3'd0) ? COPY : LIT;
      end
    end
  end

`ifdef LZ77_DEC_ERR_EN
  logic [3:0] hist_cnt;
  logic [3:0] cnt_eff;

  // A literal emitted on the accept edge is already history for the new copy.
  assign cnt_eff = hist_cnt + {3'b000, state == LIT};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_cnt <= 4'd0;
      bus.err  <= 1'b0;
    end else begin
      if (emit && hist_cnt != 4'd9) hist_cnt <= hist_cnt + 4'd1;
      if (accept && bus.match_len != 3'd0 &&
          (bus.offset > 4'd8 || bus.offset >= cnt_eff))
        bus.err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_lz77_decoder.sv
// Directed self-checking bench for lz77_decoder; err checks compile in with LZ77_DEC_ERR_EN.
module tb_lz77_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lz77_decoder_if bus ();
  lz77_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int notready = 0;
  logic [7:0] got_q [$];
  int         got_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (bus.out_valid === 1'b1) begin
      got_q.push_back(bus.out_char);
      got_cyc.push_back(cyc);
    end
    if (bus.in_ready === 1'b0) notready++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    notready = 0;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.offset    = 4'd0;
    bus.match_len = 3'd0;
    bus.char_nxt  = 8'h00;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    clear_log();
  endtask

  task automatic send(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    int   n;
    logic rd;
    bus.in_valid  = 1'b1;
    bus.offset    = o;
    bus.match_len = l;
    bus.char_nxt  = c;
    n = 0;
    do begin
      rd = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rd && n < 50);
    checks++;
    if (!rd) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", rd, n);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.offset    = 4'd0;
    bus.match_len = 3'd0;
    bus.char_nxt  = 8'h00;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_char !== 8'h00) begin failures++; $display("FAIL reset_out_char: got %h want 00", bus.out_char); end
    checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL reset_finish: got %b want 0", bus.finish); end
`ifdef LZ77_DEC_ERR_EN
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.err); end
`endif
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    clear_log();
  endtask

  task automatic test_single();
    do_reset();
    send(4'd0, 3'd0, "a");
    idle();
    wait_cycles(4);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== "a") begin failures++; $display("FAIL single_char: got %h want 61", got_q[0]); end
    checks++; if (notready != 0) begin failures++; $display("FAIL single_in_ready: low %0d cycles want 0", notready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6] = '{"a", "b", "a", "b", "a", "c"};
    do_reset();
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd0, "b");
    send(4'd1, 3'd3, "c");
    idle();
    wait_cycles(8);
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (got_q.size() == 6 && got_cyc[5] - got_cyc[0] != 5) begin
      failures++; $display("FAIL b2b_bubble: span %0d cycles want 5", got_cyc[5] - got_cyc[0]);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] exp [8] = '{"a", "b", "b", "b", "b", "b", "b", "x"};
    do_reset();
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd0, "b");
    send(4'd0, 3'd5, "x");
    idle();
    wait_cycles(10);
    checks++; if (got_q.size() != 8) begin failures++; $display("FAIL overlap_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL overlap_char[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
      end
    end
    checks++; if (got_q.size() == 8 && got_cyc[7] - got_cyc[0] != 7) begin failures++; $display("FAIL overlap_bubble: span %0d want 7", got_cyc[7] - got_cyc[0]); end
    checks++; if (notready != 5) begin failures++; $display("FAIL overlap_in_ready: low %0d cycles want 5", notready); end
  endtask

  task automatic test_offset_clamp();
    logic [7:0] ch;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ch = 8'h41 + 8'(i);
      send(4'd0, 3'd0, ch);
    end
    send(4'd15, 3'd1, "z");
    idle();
    wait_cycles(6);
    checks++; if (got_q.size() != 11) begin failures++; $display("FAIL clamp_count: got %0d want 11", got_q.size()); end
    checks++; if (got_q.size() == 11 && got_q[9] !== 8'h41) begin failures++; $display("FAIL clamp_hist8: got %h want 41", got_q[9]); end
    checks++; if (got_q.size() == 11 && got_q[10] !== "z") begin failures++; $display("FAIL clamp_lit: got %h want 7a", got_q[10]); end
  endtask

  task automatic test_terminator();
    do_reset();
    send(4'd0, 3'd0, 8'h24);
    idle();
    @(negedge clk);
    checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL term_finish_early: got %b want 0", bus.finish); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h24) begin failures++; $display("FAIL term_out: valid %b char %h want 1 24", bus.out_valid, bus.out_char); end
    checks++; if (bus.finish !== 1'b1) begin failures++; $display("FAIL term_finish: got %b want 1", bus.finish); end
    @(posedge clk);
    #1;
    clear_log();
    bus.in_valid  = 1'b1;
    bus.match_len = 3'd0;
    bus.char_nxt  = "y";
    wait_cycles(5);
    idle();
    wait_cycles(2);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL done_no_output: got %0d outputs want 0", got_q.size()); end
    checks++; if (notready != 7) begin failures++; $display("FAIL done_in_ready: low %0d cycles want 7", notready); end
    checks++; if (bus.finish !== 1'b1) begin failures++; $display("FAIL done_finish: got %b want 1", bus.finish); end
  endtask

  task automatic test_reset_mid_copy();
    int n;
    do_reset();
    send(4'd0, 3'd7, "z");
    idle();
    n = 0;
    while (got_q.size() < 2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++; if (got_q.size() < 2) begin failures++; $display("FAIL midcopy_start: got %0d outputs want 2", got_q.size()); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midcopy_abort: out_valid %b want 0", bus.out_valid); end
    clear_log();
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(12);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL midcopy_residue: got %0d outputs want 0", got_q.size()); end
    send(4'd0, 3'd0, "q");
    idle();
    wait_cycles(4);
    checks++; if (got_q.size() != 1 || got_q[0] !== "q") begin failures++; $display("FAIL midcopy_recover: count %0d first %h want 1 71", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

`ifdef LZ77_DEC_ERR_EN
  task automatic test_err();
    do_reset();
    send(4'd2, 3'd1, "k");
    idle();
    wait_cycles(4);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", bus.err); end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL err_count: got %0d want 2", got_q.size()); end
    checks++; if (got_q.size() == 2 && (got_q[0] !== 8'h00 || got_q[1] !== "k")) begin failures++; $display("FAIL err_decode: got %h %h want 00 6b", got_q[0], got_q[1]); end
    send(4'd0, 3'd0, "m");
    idle();
    wait_cycles(3);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    do_reset();
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd0, "b");
    send(4'd1, 3'd1, "c");
    idle();
    wait_cycles(5);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_legal: got %b want 0", bus.err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overlap();
    test_offset_clamp();
    test_terminator();
    test_reset_mid_copy();
`ifdef LZ77_DEC_ERR_EN
    test_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lz77_decoder.md
LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  an LZ77 code triple is presented.
REQ-005 in_ready  output  1  the decoder accepts the triple at this edge when in_valid is also high.
REQ-006 offset  input  4  match distance minus one: 0 = most recent decoded char; legal range 0..8.
REQ-007 match_len  input  3  number of chars copied from history, 0..7.
REQ-008 char_nxt  input  8  literal appended after the copy.
REQ-009 out_valid  output  1  out_char holds one decoded char this cycle.
REQ-010 out_char  output  8  decoded char.
REQ-011 finish  output  1  the terminator 8'h24 has been emitted; sticky.

Function
REQ-012 History SHALL be a 9-entry shift buffer hist[0..8], with hist[0] = newest char; every emitted char SHALL shift into hist[0].
REQ-013 The FSM SHALL have states IDLE, COPY, LIT and DONE.
REQ-014 in_ready SHALL be 1 in IDLE or LIT and 0 in COPY or DONE.
REQ-015 Accept (in_valid & in_ready at an edge):
- latch offset, match_len and char_nxt;
- go to COPY if match_len > 0, otherwise go to LIT;
- set remaining count rem = match_len.
REQ-016 COPY edge:
- out_char <= hist[offset], out_valid <= 1, shift that char into history;
- rem <= rem - 1;
- go to LIT when rem == 1.
REQ-017 LIT edge:
- out_char <= latched char_nxt, out_valid <= 1, shift it into history;
- if char_nxt == 8'h24: finish <= 1 and go to DONE;
- else if a new triple is accepted at the same edge: apply REQ-015;
- otherwise go to IDLE.
REQ-018 Because the history shifts each COPY edge while the index stays at offset, overlapping copies (match_len > offset + 1) SHALL replicate correctly.
REQ-019 In any cycle with no emission edge, out_valid SHALL be 0.
REQ-020 A triple SHALL produce exactly match_len + 1 outputs on consecutive edges; back-to-back triples SHALL stream with no bubble.
REQ-021 An offset of 9..15 SHALL read hist[8].
REQ-022 DONE SHALL be terminal until reset: in_ready = 0, out_valid = 0, finish = 1, and in_valid is ignored.

Reset
REQ-023 Reset asserted SHALL force, asynchronously:
- state IDLE, rem 0, hist[] = 8'h00, history count 0;
- out_valid 0, out_char 8'h00, finish 0.
REQ-024 Reset asserted mid-copy SHALL abort the triple with no further outputs.
REQ-025 in_ready SHALL be 1 from the first cycle after reset is released.

Configuration
REQ-026 Macro LZ77_DEC_ERR_EN defined SHALL add output err (1 bit, reset 0, sticky) that is set at the accept edge when either condition holds:
- match_len > 0 and offset > 8;
- match_len > 0 and offset >= hist_cnt, where hist_cnt is a saturating 0..9 count of emitted chars.
REQ-027 Setting err SHALL NOT alter the decode behaviour.
REQ-028 Macro LZ77_DEC_ERR_EN undefined SHALL remove err and hist_cnt; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then (0,0,'a') -> out_valid one cycle, out_char 'a', in_ready held high.
REQ-030 Feed (0,0,'a'), (0,0,'b'), then (1,3,'c') -> outputs a,b,a,b,a,c on consecutive cycles with no bubble.
REQ-031 After "ab", feed (0,5,'x') -> outputs b,b,b,b,b,x; in_ready 0 for 5 cycles.
REQ-032 Feed (0,0,8'h24) -> out_char 8'h24, finish 1 next cycle; later in_valid causes no output and in_ready stays 0.
REQ-033 Drop reset mid-COPY of (0,7,'z') -> out_valid 0 immediately; after release, (0,0,'q') decodes to 'q'.
REQ-034 With LZ77_DEC_ERR_EN, first triple (2,1,'k') -> err 1 and output still emitted; err stays 1 until reset.
